hash_arbiter: RTL

- Shares one full_hash core between N_REQ byte-stream requesters.
- Grants requesters round-robin and issues the core start pulse.
- Forwards the granted stream byte by byte on the core F_dr/F_rtr handshake, then raises End_of_File.
- Waits for H_ready and returns R_h to the owner. A watchdog aborts a hung core.

---
 rtl/hash_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/hash_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hash_arb_pkg.sv
// Shared types and sizing helpers for the hash-core arbiter.
package hash_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        STREAM = 3'd2,
        FINISH = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HASH_W = 32;

    // Watchdog counts 0..TIMEOUT_CYC-1, so $clog2 bits are enough.
    function automatic int wd_width(input int timeout_cyc);
        return (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above last_i, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDX_W'((int'(last_i) + i) % N_REQ);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash_arbiter.sv
// Time-shares one full_hash core among N_REQ byte-stream requesters,
// forwarding the owner's bytes and returning the hash (or a timeout) to it.
module hash_arbiter
    import hash_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [8*N_REQ-1:0]    s_byte_i,
    input  logic [N_REQ-1:0]      s_valid_i,
    input  logic [N_REQ-1:0]      s_last_i,
    output logic [N_REQ-1:0]      s_ready_o,
    output logic [N_REQ-1:0]      grant_o,
    output logic [31:0]           res_o,
    output logic [N_REQ-1:0]      res_valid_o,
    output logic                  res_err_o,
    output logic                  busy_o,
    output logic                  h_start_o,
    output logic [7:0]            h_byte_o,
    output logic                  h_f_dr_o,
    output logic                  h_eof_o,
    input  logic                  h_f_rtr_i,
    input  logic                  h_ready_i,
    input  logic [31:0]           h_r_h_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = wd_width(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

    state_e               state_q;
    logic [N_REQ-1:0]     grant_q;
    logic [IDX_W-1:0]     gidx_q;
    logic [IDX_W-1:0]     last_q;
    logic [WD_W-1:0]      wd_q;
    logic                 last_pend_q;
    logic                 busy_q;
    logic                 h_start_q;
    logic [BYTE_W-1:0]    h_byte_q;
    logic                 h_f_dr_q;
    logic                 h_eof_q;
    logic [HASH_W-1:0]    res_q;
    logic                 res_err_q;
    logic [N_REQ-1:0]     res_valid_q;

    logic [N_REQ-1:0]     arb_gnt;
    logic                 arb_vld;
    logic [IDX_W-1:0]     arb_idx;
    logic                 sel_valid;
    logic                 sel_last;
    logic [BYTE_W-1:0]    sel_byte;
    logic                 stream_rdy;
    logic                 accept;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (req_i),
        .last_i  (last_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_vld)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) arb_idx = IDX_W'(i);
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                sel_valid = s_valid_i[i];
                sel_last  = s_last_i[i];
                sel_byte  = s_byte_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // F_dr doubles as the guard: no byte is taken while a pulse is in flight.
    assign stream_rdy = (state_q == STREAM) && h_f_rtr_i && !h_f_dr_q;
    assign accept     = stream_rdy && sel_valid;
    assign s_ready_o  = stream_rdy ? grant_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            wd_q        <= '0;
            last_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            h_start_q   <= 1'b0;
            h_byte_q    <= '0;
            h_f_dr_q    <= 1'b0;
            h_eof_q     <= 1'b0;
            res_q       <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= '0;
        end else begin
            h_start_q   <= 1'b0;
            h_f_dr_q    <= 1'b0;
            res_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_vld) begin
                        grant_q   <= arb_gnt;
                        gidx_q    <= arb_idx;
                        h_start_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: state_q <= STREAM;
                STREAM: begin
                    if (accept) begin
                        h_byte_q    <= sel_byte;
                        h_f_dr_q    <= 1'b1;
                        last_pend_q <= sel_last;
                    end else if (h_f_dr_q && last_pend_q) begin
                        last_pend_q <= 1'b0;
                        h_eof_q     <= 1'b1;
                        wd_q        <= '0;
                        state_q     <= FINISH;
                    end
                end
                FINISH: begin
                    // A ready core in the expiry cycle still delivers its hash.
                    if (h_ready_i) begin
                        res_q       <= h_r_h_i;
                        res_err_q   <= 1'b0;
                        res_valid_q <= grant_q;
                        state_q     <= DONE;
                    end else if (wd_q == WD_MAX) begin
                        res_q       <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= grant_q;
                        state_q     <= DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                DONE: begin
                    h_eof_q <= 1'b0;
                    wd_q    <= '0;
                    grant_q <= '0;
                    last_q  <= gidx_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;
    assign res_err_o   = res_err_q;
    assign busy_o      = busy_q;
    assign h_start_o   = h_start_q;
    assign h_byte_o    = h_byte_q;
    assign h_f_dr_o    = h_f_dr_q;
    assign h_eof_o     = h_eof_q;

endmodule
